// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, presents it to a combinational-read
// instruction memory, and hands fetched words to decode over valid/ready.
module imem_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_WORDS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        halt,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_instr,
   output logic        mem_we,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   input  logic        ld_valid,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data,
   output logic        ld_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        out_ready,
   output logic        fault,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic        out_valid_n;
   logic [31:0] out_instr_n;
   logic [31:0] out_pc_n;
   logic        fault_n;
   logic [31:0] fetch_count_n;

   logic        pc_ok;
   logic        ld_ok;
   logic        handshake;
   logic [31:0] count_inc;

   assign pc_ok     = (pc[1:0] == 2'b00) && (pc[31:2] < 30'(MEM_WORDS));
   assign ld_ok     = (ld_addr[1:0] == 2'b00) && (ld_addr[31:2] < 30'(MEM_WORDS));
   assign handshake = out_valid & out_ready;
   assign count_inc = (fetch_count == 32'hFFFF_FFFF) ? fetch_count : fetch_count + 32'd1;

   assign imem_pc   = pc;
   assign mem_waddr = ld_addr;
   assign mem_wdata = ld_data;

   // The loader port is gated by rst_n so that neither strobe can assert while
   // reset holds the state register at IDLE.
   assign ld_ready  = rst_n && (state == S_IDLE);
   assign mem_we    = ld_ready && ld_valid && ld_ok;

   // NOTE: every next-state variable is defaulted to its current value first,
   // so no path through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_n       = state;
      pc_n          = pc;
      out_valid_n   = out_valid;
      out_instr_n   = out_instr;
      out_pc_n      = out_pc;
      fault_n       = fault;
      fetch_count_n = fetch_count;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_n     = S_RUN;
               pc_n        = RESET_PC;
               out_valid_n = 1'b0;
            end
         end

         S_RUN: begin
            if (redirect_valid) begin
               // The in-flight word is cancelled, so its handshake is not counted.
               out_valid_n = 1'b0;
               pc_n        = redirect_pc;
               if (halt) state_n = S_IDLE;
            end else if (!pc_ok) begin
               state_n     = S_FAULT;
               fault_n     = 1'b1;
               out_valid_n = 1'b0;
            end else if (halt) begin
               state_n     = S_IDLE;
               out_valid_n = 1'b0;
               if (handshake) fetch_count_n = count_inc;
            end else if (!out_valid || out_ready) begin
               out_instr_n = imem_instr;
               out_pc_n    = pc;
               out_valid_n = 1'b1;
               pc_n        = pc + 32'd4;
               if (handshake) fetch_count_n = count_inc;
            end
         end

         S_FAULT: begin
            if (start) begin
               state_n     = S_RUN;
               fault_n     = 1'b0;
               pc_n        = RESET_PC;
               out_valid_n = 1'b0;
            end
         end

         default: begin
            state_n     = S_IDLE;
            out_valid_n = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before this edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         out_valid   <= 1'b0;
         out_instr   <= 32'd0;
         out_pc      <= 32'd0;
         fault       <= 1'b0;
         fetch_count <= 32'd0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         out_valid   <= out_valid_n;
         out_instr   <= out_instr_n;
         out_pc      <= out_pc_n;
         fault       <= fault_n;
         fetch_count <= fetch_count_n;
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a vector table for the fetch/redirect/fault
// flow, plus hand sequences for the loader and an asynchronous mid-run reset.
module tb_imem_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        halt = 1'b0;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr;
   logic        mem_we;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic        ld_valid = 1'b0;
   logic [31:0] ld_addr = 32'd0;
   logic [31:0] ld_data = 32'd0;
   logic        ld_ready;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready = 1'b0;
   logic        fault;
   logic [31:0] fetch_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   imem_fetch_ctrl #(.RESET_PC(32'h0), .MEM_WORDS(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
      .imem_pc(imem_pc), .imem_instr(imem_instr),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
      .fault(fault), .fetch_count(fetch_count)
   );

   // Instruction memory model: combinational read, write on the rising edge.
   logic [31:0] mem [16];
   assign imem_instr = (imem_pc[31:6] == 26'd0) ? mem[imem_pc[5:2]] : 32'hDEAD_BEEF;
   always @(posedge clk) if (mem_we) mem[mem_waddr[5:2]] <= mem_wdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        start, halt, rdy, rv;
      logic [31:0] rpc;
      logic        ev;
      logic [31:0] epc, einstr, ecnt, eimem;
      logic        efault;
   } vec_t;

   vec_t vecs[24];

   function automatic vec_t mk(input logic s, h, r, rv, input logic [31:0] rpc,
                               input logic ev, input logic [31:0] epc, ei, ec, eim,
                               input logic ef);
      vec_t v;
      v.start = s; v.halt = h; v.rdy = r; v.rv = rv; v.rpc = rpc;
      v.ev = ev; v.epc = epc; v.einstr = ei; v.ecnt = ec; v.eimem = eim; v.efault = ef;
      return v;
   endfunction

   task automatic step(input logic s, h, r, rv, input logic [31:0] rpc);
      start = s; halt = h; out_ready = r; redirect_valid = rv; redirect_pc = rpc;
      @(posedge clk); #1;
      start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
   endtask

   initial begin
      mem[0] = 32'h0000_0013;
      mem[1] = 32'h0050_0093;
      mem[2] = 32'h0060_0113;
      mem[3] = 32'h0020_81B3;
      mem[4] = 32'h0031_0023;
      for (int i = 5; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);

      //            st h  rd rv rpc       ev pc      instr         cnt imem   flt
      vecs[0]  = mk(1, 0, 1, 0, 32'h0,    0, 32'h0,  32'h0,        0, 32'h0,  0);
      vecs[1]  = mk(0, 0, 1, 0, 32'h0,    1, 32'h0,  32'h0000_0013, 0, 32'h4,  0);
      vecs[2]  = mk(0, 0, 0, 0, 32'h0,    1, 32'h0,  32'h0000_0013, 0, 32'h4,  0);
      vecs[3]  = mk(0, 0, 0, 0, 32'h0,    1, 32'h0,  32'h0000_0013, 0, 32'h4,  0);
      vecs[4]  = mk(0, 0, 0, 0, 32'h0,    1, 32'h0,  32'h0000_0013, 0, 32'h4,  0);
      vecs[5]  = mk(0, 0, 1, 0, 32'h0,    1, 32'h4,  32'h0050_0093, 1, 32'h8,  0);
      vecs[6]  = mk(0, 0, 1, 0, 32'h0,    1, 32'h8,  32'h0060_0113, 2, 32'hC,  0);
      vecs[7]  = mk(0, 0, 1, 1, 32'h10,   0, 32'h0,  32'h0,        2, 32'h10, 0);
      vecs[8]  = mk(0, 0, 1, 0, 32'h0,    1, 32'h10, 32'h0031_0023, 2, 32'h14, 0);
      vecs[9]  = mk(0, 0, 1, 0, 32'h0,    1, 32'h14, 32'h1000_0005, 3, 32'h18, 0);
      vecs[10] = mk(0, 0, 1, 1, 32'h6,    0, 32'h0,  32'h0,        3, 32'h6,  0);
      vecs[11] = mk(0, 0, 1, 0, 32'h0,    0, 32'h0,  32'h0,        3, 32'h6,  1);
      vecs[12] = mk(0, 1, 1, 0, 32'h0,    0, 32'h0,  32'h0,        3, 32'h6,  1);
      vecs[13] = mk(1, 0, 1, 0, 32'h0,    0, 32'h0,  32'h0,        3, 32'h0,  0);
      vecs[14] = mk(0, 0, 1, 0, 32'h0,    1, 32'h0,  32'h0000_0013, 3, 32'h4,  0);
      vecs[15] = mk(0, 0, 1, 1, 32'h40,   0, 32'h0,  32'h0,        3, 32'h40, 0);
      vecs[16] = mk(0, 0, 1, 0, 32'h0,    0, 32'h0,  32'h0,        3, 32'h40, 1);
      vecs[17] = mk(1, 0, 0, 0, 32'h0,    0, 32'h0,  32'h0,        3, 32'h0,  0);
      vecs[18] = mk(0, 0, 1, 0, 32'h0,    1, 32'h0,  32'h0000_0013, 3, 32'h4,  0);
      vecs[19] = mk(0, 1, 1, 0, 32'h0,    0, 32'h0,  32'h0,        4, 32'h4,  0);
      vecs[20] = mk(1, 0, 1, 0, 32'h0,    0, 32'h0,  32'h0,        4, 32'h0,  0);
      vecs[21] = mk(0, 0, 1, 0, 32'h0,    1, 32'h0,  32'h0000_0013, 4, 32'h4,  0);
      vecs[22] = mk(0, 1, 1, 1, 32'h20,   0, 32'h0,  32'h0,        4, 32'h20, 0);
      vecs[23] = mk(0, 0, 0, 0, 32'h0,    0, 32'h0,  32'h0,        4, 32'h20, 0);

      // Reset state, with a legal loader request held to prove mem_we stays low.
      ld_valid = 1'b1; ld_addr = 32'h0; ld_data = 32'h0000_0013;
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_count", fetch_count, 32'd0);
      check("rst_imem_pc", imem_pc, 32'h0);
      check("rst_ld_ready", 32'(ld_ready), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      ld_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 24; i++) begin
         step(vecs[i].start, vecs[i].halt, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
         check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
         check($sformatf("v%0d_count", i), fetch_count, vecs[i].ecnt);
         check($sformatf("v%0d_imem_pc", i), imem_pc, vecs[i].eimem);
         check($sformatf("v%0d_fault", i), 32'(fault), 32'(vecs[i].efault));
         if (vecs[i].ev) begin
            check($sformatf("v%0d_out_pc", i), out_pc, vecs[i].epc);
            check($sformatf("v%0d_out_instr", i), out_instr, vecs[i].einstr);
         end
      end

      // Loader in IDLE: legal write, dropped misaligned and out-of-range writes.
      check("ld_ready_idle", 32'(ld_ready), 32'd1);
      ld_valid = 1'b1; ld_addr = 32'h4; ld_data = 32'h00A0_0093; #1;
      check("ld_we_legal", 32'(mem_we), 32'd1);
      check("ld_waddr", mem_waddr, 32'h4);
      check("ld_wdata", mem_wdata, 32'h00A0_0093);
      @(posedge clk); #1;
      ld_addr = 32'h42; ld_data = 32'hFFFF_FFFF; #1;
      check("ld_we_misaligned", 32'(mem_we), 32'd0);
      ld_addr = 32'h40; #1;
      check("ld_we_out_of_range", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
      check("ld_drop_no_fault", 32'(fault), 32'd0);

      // start together with a loader write: the write lands, then RUN begins.
      ld_addr = 32'h8; ld_data = 32'h00B0_0113; #1;
      check("ld_we_with_start", 32'(mem_we), 32'd1);
      step(1, 0, 1, 0, 32'h0);
      ld_valid = 1'b0;
      check("run_ld_ready", 32'(ld_ready), 32'd0);
      step(0, 0, 1, 0, 32'h0);
      check("ld_f0_pc", out_pc, 32'h0);
      check("ld_f0_instr", out_instr, 32'h0000_0013);
      step(0, 0, 1, 0, 32'h0);
      check("ld_f1_pc", out_pc, 32'h4);
      check("ld_f1_instr", out_instr, 32'h00A0_0093);
      step(0, 0, 1, 0, 32'h0);
      check("ld_f2_pc", out_pc, 32'h8);
      check("ld_f2_instr", out_instr, 32'h00B0_0113);
      check("ld_f2_count", fetch_count, 32'd6);

      // Fault on the aligned-but-out-of-range target, then async reset mid-cycle.
      step(0, 0, 1, 1, 32'h44);
      step(0, 0, 1, 0, 32'h0);
      check("pre_rst_fault", 32'(fault), 32'd1);
      #3 rst_n = 1'b0; #1;
      check("async_out_valid", 32'(out_valid), 32'd0);
      check("async_fault", 32'(fault), 32'd0);
      check("async_count", fetch_count, 32'd0);
      check("async_imem_pc", imem_pc, 32'h0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_idle_ld_ready", 32'(ld_ready), 32'd1);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Sequences the instruction memory: owns the program counter, drives the memory read address, and registers each fetched word toward decode over a valid/ready handshake.
- Handles branch/jump redirects and flushes the in-flight word on a redirect.
- Shares the memory between the fetch path and a boot loader write port; the loader owns the memory only while the core is idle.
- Detects misaligned or out-of-range PCs and parks in a fault state.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset and on start.
- MEM_WORDS, 16, number of 32-bit words in instruction memory; valid word index is 0..MEM_WORDS-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; IDLE->RUN.
- halt  in  1  level; RUN->IDLE at next edge.
- imem_pc  out  32  byte address to memory; combinational word read returns imem_instr the same cycle.
- imem_instr  in  32  word read from memory.
- mem_we  out  1  write strobe to memory (loader path).
- mem_waddr  out  32  loader byte address.
- mem_wdata  out  32  loader data.
- ld_valid  in  1  loader request.
- ld_addr  in  32  loader byte address.
- ld_data  in  32  loader word.
- ld_ready  out  1  loader accept.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  32  target byte address.
- out_valid  out  1  fetched word valid.
- out_instr  out  32  fetched word.
- out_pc  out  32  address of out_instr.
- out_ready  in  1  decode accepts the word.
- fault  out  1  sticky fault flag.
- fetch_count  out  32  number of words handed to decode.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pc=RESET_PC; out_valid=0; out_instr=0; out_pc=0; fault=0; fetch_count=0; mem_we=0; ld_ready=0.
- imem_pc = pc at all times; mem_waddr = ld_addr; mem_wdata = ld_data (combinational).
- IDLE:
  - ld_ready=1. mem_we = ld_valid & ld_addr word-aligned & in range.
  - A misaligned or out-of-range load is accepted and dropped (no write, no fault).
  - start -> RUN; pc=RESET_PC; out_valid=0. If start and ld_valid occur in the same cycle, the write completes, then the state goes to RUN.
- RUN:
  - ld_ready=0; mem_we=0.
  - Redirect (highest priority): out_valid<=0 and pc<=redirect_pc. The in-flight word is dropped even if out_ready=1 that cycle; fetch_count is not incremented for it.
  - Advance, when (!out_valid | out_ready) and no redirect and pc is legal:
    - out_instr<=imem_instr; out_pc<=pc; out_valid<=1; pc<=pc+4.
    - fetch_count increments on each accepted handshake (out_valid&out_ready) not cancelled by redirect, saturating at 32'hFFFF_FFFF.
  - Stall: out_valid&!out_ready holds out_*, pc, and count unchanged.
  - Fault check applies to the pc about to be fetched: pc[1:0]!=0 or (pc>>2)>=MEM_WORDS -> FAULT; fault<=1; out_valid<=0.
  - A word already valid at the fault edge is discarded.
  - halt (no redirect) -> IDLE; out_valid<=0; pc retained.
  - Priority: redirect > fault > halt > advance. A halt with a simultaneous redirect goes to IDLE with pc=redirect_pc.
- FAULT: out_valid=0, ld_ready=0. Leaves only via reset, or via start, which clears fault and restarts at RESET_PC. halt is ignored.
- Throughput: one word per cycle with out_ready held high. Latency: pc presented -> out_valid one edge later.
- Reset mid-operation clears every register immediately, with no wait for a clock edge.

Test Plan:
- Reset, start, out_ready=1, memory {0:00000013, 1:00500093, 2:00600113, 3:002081B3} -> out_pc 0,4,8,C on consecutive cycles with matching out_instr; fetch_count=4 after 4 handshakes.
- Hold out_ready=0 for 3 cycles after the first word -> out_instr=00000013 and out_pc=0 stable; pc stays 4; the next word follows on the cycle out_ready rises.
- Redirect_pc=0x10 while out_pc=0x8 is valid with out_ready=1 -> that word is dropped, count unchanged; next out_pc=0x10, out_instr=00310023.
- Redirect_pc=0x6 -> fault=1, out_valid=0 next cycle. Redirect to 0x40 with MEM_WORDS=16 -> fault. start -> fault cleared, out_pc=0 fetched.
- In IDLE, loader writes 32'h00A00093 to 0x4 (ld_valid=1 -> mem_we=1 one cycle); write to 0x42 -> mem_we=0; then start -> out_pc=4 returns 00A00093.
- Pull rst_n low mid-RUN between clock edges -> out_valid, fault, and fetch_count are 0 immediately; the state is IDLE after release.
